scan_led_mux: RTL



---
 rtl/scan_led_pkg.sv | 42 ++++
 rtl/scan_tick_gen.sv | 43 ++++
 rtl/scan_led_mux.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/scan_led_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
package scan_led_pkg;

    // Widest digit-select vector any configuration can ask for.
    localparam int MAX_DIGITS = 16;

    // Active-low pattern with every segment (and the decimal point) dark.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bit position of the decimal point in {dp,g,f,e,d,c,b,a}.
    localparam int DP_BIT = 7;

    // Hex digit to active-low segment pattern, decimal point left dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Digit-select vector with every digit switched off, for either polarity.
    function automatic logic [MAX_DIGITS-1:0] dig_inactive(input bit act_low);
        return act_low ? {MAX_DIGITS{1'b1}} : {MAX_DIGITS{1'b0}};
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan prescaler: splits each digit slot into 2^BRIGHT_W equal sub-slots.
module scan_tick_gen #(
    parameter int DIV      = 8,
    parameter int BRIGHT_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    output logic [BRIGHT_W-1:0] sub_idx,
    output logic                sub_tick,
    output logic                slot_end
);

    localparam int NSUB  = 1 << BRIGHT_W;
    localparam int SUB   = DIV / NSUB;
    localparam int CNT_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(SUB - 1);

    if (DIV < NSUB) begin : g_err_div_small
        $error("scan_tick_gen: DIV must be at least 2^BRIGHT_W");
    end
    if ((DIV % NSUB) != 0) begin : g_err_div_mod
        $error("scan_tick_gen: DIV must be a multiple of 2^BRIGHT_W");
    end

    logic [CNT_W-1:0] sub_cnt;

    assign sub_tick = (sub_cnt == SUB_LAST);
    assign slot_end = sub_tick && (&sub_idx);

    // Clock counter within a sub-slot, and the sub-slot index within a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt <= '0;
            sub_idx <= '0;
        end else if (sub_tick) begin
            sub_cnt <= '0;
            sub_idx <= sub_idx + 1'b1;
        end else begin
            sub_cnt <= sub_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_led_mux.sv
// Multiplexed seven-segment driver with double-buffered data, leading-zero
// blanking, per-digit decimal points and PWM brightness.
// update is a single-cycle capture strobe with no back-pressure: every clock
// in which it is high overwrites the pending buffer.
module scan_led_mux
    import scan_led_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int CLK_HZ      = 50000000,
    parameter int SCAN_HZ     = 1000,
    parameter int BRIGHT_W    = 3,
    parameter bit DIG_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   d,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  update,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [DIGITS-1:0]     dig,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]      IDX_TOP     = IDX_W'(DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] DIG_OFF_ALL = dig_inactive(DIG_ACT_LOW);
    localparam logic [DIGITS-1:0]     DIG_OFF     = DIG_OFF_ALL[DIGITS-1:0];
    localparam logic [7:0]            SEG_OFF     = SEG_ACT_LOW ? SEG_BLANK : ~SEG_BLANK;

    if (DIGITS < 2 || DIGITS > MAX_DIGITS) begin : g_err_digits
        $error("scan_led_mux: DIGITS must be in 2..16");
    end

    logic [BRIGHT_W-1:0] sub_idx;
    logic                sub_tick;
    logic                slot_end;

    scan_tick_gen #(
        .DIV      (DIV),
        .BRIGHT_W (BRIGHT_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .sub_idx  (sub_idx),
        .sub_tick (sub_tick),
        .slot_end (slot_end)
    );

    logic [IDX_W-1:0]    idx;
    logic                frame_wrap;
    logic                wrap_d;
    logic                tick_d;
    logic [4*DIGITS-1:0] pend_d;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_v;
    logic [4*DIGITS-1:0] shd_d;
    logic [DIGITS-1:0]   shd_dp;
    logic [DIGITS-1:0]   lz_blank;
    logic                all_zero;
    logic [7:0]          seg_nxt;
    logic [DIGITS-1:0]   dig_nxt;

    assign frame_wrap = slot_end && (idx == '0);

    // Digit index scans leftmost to rightmost; remember when a frame wraps
    // and when the counters moved so the outputs can follow one clock later.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= IDX_TOP;
            wrap_d <= 1'b1;
            tick_d <= 1'b1;
        end else begin
            wrap_d <= frame_wrap;
            tick_d <= sub_tick;
            if (slot_end) begin
                idx <= (idx == '0) ? IDX_TOP : idx - 1'b1;
            end
        end
    end

    // Pending buffer takes every update; shadow swaps only at the frame wrap
    // so a frame is never drawn from two different data sets.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_d  <= '0;
            pend_dp <= '0;
            pend_v  <= 1'b0;
            shd_d   <= '0;
            shd_dp  <= '0;
        end else begin
            if (frame_wrap && pend_v) begin
                shd_d  <= pend_d;
                shd_dp <= pend_dp;
                pend_v <= 1'b0;
            end
            if (update) begin
                pend_d  <= d;
                pend_dp <= dp;
                pend_v  <= 1'b1;
            end
        end
    end

    // Blank a digit when it and every digit to its left are zero.
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero && (shd_d[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_en && (i != 0) && all_zero;
        end
    end

    // Segment pattern and digit select for the current slot and sub-slot.
    always_comb begin
        seg_nxt = lz_blank[idx] ? SEG_BLANK : hex_to_seg(shd_d[{idx, 2'b00} +: 4]);
        if (shd_dp[idx]) begin
            seg_nxt[DP_BIT] = 1'b0;
        end
        if (!SEG_ACT_LOW) begin
            seg_nxt = ~seg_nxt;
        end
        dig_nxt = DIG_OFF;
        if (sub_idx <= bright) begin
            dig_nxt[idx] = ~DIG_OFF[idx];
        end
    end

    // Registered pin drivers; dig and seg always change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig         <= DIG_OFF;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap_d;
            if (tick_d) begin
                dig <= dig_nxt;
                seg <= seg_nxt;
            end
        end
    end

endmodule
